// File: rtl/edge_pkg.sv
// Shared widths and default sizing for the edge binarise-and-pack datapath.
package edge_pkg;
  localparam int MAG_W          = 8;
  localparam int BYTE_W         = 8;
  localparam int LINE_W_DEF     = 640;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/edge_bin_packer_if.sv
// Pixel-in / packed-byte-out stream bundle; slave is the packer, master drives pixels and ready.
interface edge_bin_packer_if;
  import edge_pkg::*;

  logic              i_vld;
  logic [MAG_W-1:0]  i_mag;
  logic              i_sof;
  logic              i_rdy;
  logic              o_vld;
  logic [BYTE_W-1:0] o_data;

  modport slave  (input  i_vld, i_mag, i_sof, i_rdy, output o_vld, o_data);
  modport master (output i_vld, i_mag, i_sof, i_rdy, input  o_vld, o_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push while full is accepted only alongside a pop.
// Head is combinational from storage, so it holds steady until popped.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_wr_en;
  logic         w_rd_en;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/edge_bin_packer.sv
// Thresholds edge magnitudes to bits, packs them LSB-first into bytes per line and queues them;
// byte visible one cycle after its completing pixel, held while !i_rdy, dropped (sticky o_ovf) if FIFO full.
module edge_bin_packer
  import edge_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  edge_bin_packer_if.slave             io_bus,
  input  logic [MAG_W-1:0]             i_thr,
  output logic [$clog2(LINE_W+1)-1:0]  o_cnt,
  output logic                         o_cnt_vld,
  output logic                         o_ovf
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int CNT_W = $clog2(LINE_W+1);

  logic [COL_W-1:0]  r_col;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic [CNT_W-1:0]  r_ecnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cnt_vld;
  logic              r_ovf;

  logic              w_edge;
  logic [COL_W-1:0]  w_col;
  logic [2:0]        w_bit;
  logic [BYTE_W-1:0] w_byte;
  logic [CNT_W-1:0]  w_ecnt;
  logic              w_eol;
  logic              w_done;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;

  // A start-of-frame pixel sees an empty line context, which discards any partial byte and count.
  assign w_edge = (io_bus.i_mag >= i_thr);
  assign w_col  = io_bus.i_sof ? '0 : r_col;
  assign w_bit  = io_bus.i_sof ? '0 : r_bit;
  assign w_byte = (io_bus.i_sof ? '0 : r_byte) | ({{(BYTE_W-1){1'b0}}, w_edge} << w_bit);
  assign w_ecnt = (io_bus.i_sof ? '0 : r_ecnt) + CNT_W'(w_edge);
  assign w_eol  = (w_col == COL_W'(LINE_W-1));
  assign w_done = w_eol || (w_bit == 3'd7);
  assign w_push = io_bus.i_vld && w_done;
  assign w_pop  = io_bus.o_vld && io_bus.i_rdy;

  sync_fifo #(.W(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_byte),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io_bus.o_vld  = !w_empty;
  assign io_bus.o_data = w_empty ? '0 : w_head;
  assign o_cnt         = r_cnt;
  assign o_cnt_vld     = r_cnt_vld;
  assign o_ovf         = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_ecnt    <= '0;
      r_cnt     <= '0;
      r_cnt_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_cnt_vld <= 1'b0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (io_bus.i_vld) begin
        if (w_eol) begin
          r_col     <= '0;
          r_ecnt    <= '0;
          r_cnt     <= w_ecnt;
          r_cnt_vld <= 1'b1;
        end else begin
          r_col  <= w_col + 1'b1;
          r_ecnt <= w_ecnt;
        end
        if (w_done) begin
          r_bit  <= '0;
          r_byte <= '0;
        end else begin
          r_bit  <= w_bit + 3'd1;
          r_byte <= w_byte;
        end
      end
    end
  end
endmodule

// File: tb/tb_edge_bin_packer.sv
// Directed bench: a 16-pixel-line packer for most cases plus a 12-pixel-line packer for the partial-byte case.
module tb_edge_bin_packer;
  import edge_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] thr = 8'd0;
  logic       sel = 1'b0;
  logic [4:0] cnt16;
  logic [3:0] cnt12;
  logic       cv16, cv12, ovf16, ovf12;

  int total = 0;
  int bad   = 0;

  logic [7:0] q16[$];
  logic [7:0] q12[$];
  int np16 = 0, np12 = 0, lc16 = 0, lc12 = 0;

  edge_bin_packer_if if16();
  edge_bin_packer_if if12();

  edge_bin_packer #(.LINE_W(16), .FIFO_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst), .io_bus(if16), .i_thr(thr),
    .o_cnt(cnt16), .o_cnt_vld(cv16), .o_ovf(ovf16)
  );

  edge_bin_packer #(.LINE_W(12), .FIFO_DEPTH(4)) dut12 (
    .clk(clk), .rst(rst), .io_bus(if12), .i_thr(thr),
    .o_cnt(cnt12), .o_cnt_vld(cv12), .o_ovf(ovf12)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic px(input logic [7:0] m, input logic s, input logic [7:0] t);
    @(posedge clk); #1;
    thr = t;
    if (sel) begin
      if12.i_vld = 1'b1; if12.i_mag = m; if12.i_sof = s;
    end else begin
      if16.i_vld = 1'b1; if16.i_mag = m; if16.i_sof = s;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if16.i_vld = 1'b0; if16.i_sof = 1'b0;
      if12.i_vld = 1'b0; if12.i_sof = 1'b0;
    end
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    if16.i_vld = 1'b0; if12.i_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Consumer side: record every accepted byte and every line-count pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (if16.o_vld && if16.i_rdy) q16.push_back(if16.o_data);
      if (if12.o_vld && if12.i_rdy) q12.push_back(if12.o_data);
      if (cv16) begin np16++; lc16 = int'(cnt16); end
      if (cv12) begin np12++; lc12 = int'(cnt12); end
    end
  end

  initial begin
    int b, p;
    if16.i_vld = 1'b0; if16.i_mag = '0; if16.i_sof = 1'b0; if16.i_rdy = 1'b1;
    if12.i_vld = 1'b0; if12.i_mag = '0; if12.i_sof = 1'b0; if12.i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld",  int'(if16.o_vld), 0);
    chk("rst_data", int'(if16.o_data), 0);
    chk("rst_cnt",  int'(cnt16), 0);
    chk("rst_cntv", int'(cv16), 0);
    chk("rst_ovf",  int'(ovf16), 0);

    // Alternating strong/weak edges over one line.
    b = q16.size(); p = np16;
    for (int i = 0; i < 16; i++) begin
      px((i % 2 == 0) ? 8'd200 : 8'd10, 1'b0, 8'd128);
      if (i == 8) begin
        @(negedge clk);
        chk("alt_lat_vld",  int'(if16.o_vld), 1);
        chk("alt_lat_data", int'(if16.o_data), 8'h55);
      end
    end
    idle(4);
    chk("alt_nbytes", q16.size() - b, 2);
    chk("alt_b0", int'(q16[b]), 8'h55);
    chk("alt_b1", int'(q16[b+1]), 8'h55);
    chk("alt_pulses", np16 - p, 1);
    chk("alt_cnt", lc16, 8);

    // Line length not a multiple of 8: trailing byte zero-padded.
    sel = 1'b1;
    b = q12.size(); p = np12;
    for (int i = 0; i < 12; i++) px(8'd255, 1'b0, 8'd100);
    idle(4);
    sel = 1'b0;
    chk("l12_nbytes", q12.size() - b, 2);
    chk("l12_b0", int'(q12[b]), 8'hFF);
    chk("l12_b1", int'(q12[b+1]), 8'h0F);
    chk("l12_pulses", np12 - p, 1);
    chk("l12_cnt", lc12, 12);

    // Start-of-frame mid-byte discards the partial byte and count.
    do_rst();
    b = q16.size(); p = np16;
    for (int i = 0; i < 3; i++) px(8'd50, 1'b0, 8'd50);
    px(8'd0, 1'b1, 8'd50);
    for (int i = 0; i < 7; i++) px(8'd0, 1'b0, 8'd50);
    idle(4);
    chk("sof_nbytes", q16.size() - b, 1);
    chk("sof_b0", int'(q16[b]), 8'h00);
    chk("sof_pulses", np16 - p, 0);

    // Overflow: 5 bytes into a 4-deep FIFO while stalled.
    do_rst();
    if16.i_rdy = 1'b0;
    b = q16.size(); p = np16;
    for (int i = 0; i < 32; i++) px(8'd255, 1'b0, 8'd128);
    idle(1);
    @(negedge clk);
    chk("ovf_full_noovf", int'(ovf16), 0);
    chk("ovf_full_vld", int'(if16.o_vld), 1);
    for (int i = 0; i < 8; i++) px(8'd255, 1'b0, 8'd128);
    idle(1);
    @(negedge clk);
    chk("ovf_set", int'(ovf16), 1);
    chk("ovf_hold_data", int'(if16.o_data), 8'hFF);
    chk("ovf_pulses", np16 - p, 2);
    chk("ovf_cnt", lc16, 16);
    @(posedge clk); #1;
    if16.i_rdy = 1'b1;
    idle(8);
    @(negedge clk);
    chk("ovf_drain_n", q16.size() - b, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("ovf_drain_b%0d", k), int'(q16[b+k]), 8'hFF);
    chk("ovf_drain_vld", int'(if16.o_vld), 0);
    chk("ovf_sticky", int'(ovf16), 1);

    // Reset mid-line clears outputs and all partial state.
    for (int i = 0; i < 5; i++) px(8'd255, 1'b0, 8'd128);
    @(posedge clk); #1;
    if16.i_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_vld",  int'(if16.o_vld), 0);
    chk("mrst_data", int'(if16.o_data), 0);
    chk("mrst_cnt",  int'(cnt16), 0);
    chk("mrst_cntv", int'(cv16), 0);
    chk("mrst_ovf",  int'(ovf16), 0);
    b = q16.size(); p = np16;
    for (int i = 0; i < 16; i++) px(8'd0, 1'b0, 8'd128);
    idle(4);
    chk("mrst_nbytes", q16.size() - b, 2);
    chk("mrst_b0", int'(q16[b]), 8'h00);
    chk("mrst_b1", int'(q16[b+1]), 8'h00);
    chk("mrst_pulses", np16 - p, 1);
    chk("mrst_cnt_line", lc16, 0);

    // Threshold extremes: thr=0 always sets, thr=255 only on 255.
    do_rst();
    b = q16.size(); p = np16;
    px(8'd0, 1'b0, 8'd0);   px(8'd1, 1'b0, 8'd0);
    px(8'd7, 1'b0, 8'd0);   px(8'd128, 1'b0, 8'd0);
    px(8'd255, 1'b0, 8'd0); px(8'd3, 1'b0, 8'd0);
    px(8'd64, 1'b0, 8'd0);  px(8'd9, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) px((i % 2 == 0) ? 8'd255 : 8'd254, 1'b0, 8'd255);
    idle(4);
    chk("thr_nbytes", q16.size() - b, 2);
    chk("thr0_b", int'(q16[b]), 8'hFF);
    chk("thr255_b", int'(q16[b+1]), 8'h55);
    chk("thr_cnt", lc16, 12);
    chk("thr_pulses", np16 - p, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_bin_packer.md
EDGE_BIN_PACKER -- requirements
Module: edge_bin_packer

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning pixels per line (range 8..4095).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output byte FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_vld  input  1  magnitude sample valid.
REQ-006 SHALL have port i_mag  input  8  edge magnitude sample.
REQ-007 SHALL have port i_sof  input  1  first pixel of frame, qualified by i_vld.
REQ-008 SHALL have port i_thr  input  8  binarisation threshold.
REQ-009 SHALL have port i_rdy  input  1  downstream ready for o_data.
REQ-010 SHALL have port o_vld  output  1  o_data valid.
REQ-011 SHALL have port o_data  output  8  packed edge bits.
REQ-012 SHALL have port o_cnt  output  clog2(LINE_W+1)  edge pixel count of last completed line.
REQ-013 SHALL have port o_cnt_vld  output  1  one-cycle pulse when o_cnt updates.
REQ-014 SHALL have port o_ovf  output  1  sticky FIFO overflow flag.

Function
REQ-015 Each cycle with i_vld=1 SHALL produce edge bit = (i_mag >= i_thr), unsigned compare, i_thr sampled that same cycle.
REQ-016 Edge bits SHALL pack LSB-first: first pixel of a byte at bit 0.
REQ-017 Column counter SHALL advance 0..LINE_W-1 per valid pixel and wrap to 0 after column LINE_W-1 (end of line).
REQ-018 A byte SHALL complete on its 8th bit or at end of line; a partial byte at end of line SHALL be zero-padded in unused upper bits.
REQ-019 A completed byte SHALL be written to the FIFO on the cycle after its completing pixel; with FIFO empty and i_rdy=1, o_vld SHALL assert that cycle (1-cycle latency).
REQ-020 o_vld SHALL equal FIFO not-empty; o_data SHALL be the head entry; pop SHALL occur on o_vld && i_rdy; o_data SHALL be stable while o_vld && !i_rdy.
REQ-021 Push when full without simultaneous pop SHALL drop the new byte, keep FIFO contents, and set o_ovf=1 until reset.
REQ-022 Simultaneous push and pop when full SHALL succeed with no overflow.
REQ-023 Edge counter SHALL count set bits per line; at end of line o_cnt SHALL load the total including the last pixel, o_cnt_vld SHALL pulse once, counter SHALL restart at 0.
REQ-024 i_vld && i_sof SHALL treat that pixel as column 0 of a new line: pending partial byte and partial edge count discarded (not pushed, no o_cnt_vld), FIFO contents kept.
REQ-025 i_sof with i_vld=0 SHALL be ignored.
REQ-026 Cycles with i_vld=0 SHALL change no packing or counting state.

Reset
REQ-027 With rst=1 at a clock edge: FIFO emptied, o_vld=0, o_data=0, o_cnt=0, o_cnt_vld=0, o_ovf=0, column, bit and edge counters 0.
REQ-028 Reset mid-line or mid-byte SHALL discard all partial state; no stale byte SHALL appear after rst deasserts.

Structure
REQ-029 Shared package edge_pkg SHALL hold magnitude width (8), default LINE_W and FIFO_DEPTH constants.
REQ-030 FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, full/empty, same clk/rst).

Verification (bench LINE_W=16 unless stated)
REQ-031 thr=128, mags alternating 200,10 for 16 pixels, i_rdy=1 -> o_data 0x55, 0x55; o_cnt=8 with one o_cnt_vld pulse.
REQ-032 LINE_W=12, thr=100, 12 pixels of 255 -> o_data 0xFF then 0x0F; o_cnt=12.
REQ-033 i_rdy=0, FIFO_DEPTH=4, 40 pixels of 255 (5 bytes) -> o_ovf=1 after 5th byte; then i_rdy=1 drains exactly 4 bytes 0xFF, o_vld low afterwards.
REQ-034 thr=50, 3 pixels mag=50, then i_sof pixel mag=0 followed by 7 pixels mag=0 -> single byte 0x00 pushed, no 0x07; no o_cnt_vld.
REQ-035 rst=1 after 5 pixels of 255 mid-line -> next cycle all outputs 0; 16 fresh pixels of 0 yield only 0x00, 0x00, o_cnt=0.
REQ-036 thr=0, any mags -> all bits 1; thr=255 with mag=255 -> bit 1, mag=254 -> bit 0.
